param_deserializer: RTL and testbench
=====================================

PARAM_DESERIALIZER -- requirements
Module: param_deserializer

Interface
REQ-001 SHALL have parameter WIDTH, default 8, assembled word width in bits (>=2).
REQ-002 SHALL have parameter DEPTH, default 4, output buffer depth in words (power of 2, >=2).
REQ-003 SHALL have parameter MSB_FIRST, default 1; 1 = first received bit lands in data_out[WIDTH-1], 0 = first bit lands in data_out[0].
REQ-004 SHALL have port clock_100  input  1  sole clock, rising-edge.
REQ-005 SHALL have port reset  input  1  asynchronous active-low reset (asserted at 0).
REQ-006 SHALL have port data_in  input  1  serial data bit.
REQ-007 SHALL have port write_in  input  1  data_in valid this cycle.
REQ-008 SHALL have port ack_in  input  1  consumer pops head word.
REQ-009 SHALL have port in_ready  output  1  1 = buffer not full, bits accepted.
REQ-010 SHALL have port data_out  output  WIDTH  buffer head word.
REQ-011 SHALL have port data_ready  output  1  buffer non-empty.
REQ-012 SHALL have port status_out  output  1  partial word in progress.
REQ-013 SHALL have port word_count  output  $clog2(DEPTH+1)  words held.
REQ-014 SHALL have port overflow  output  1  sticky: bit dropped while full.
REQ-015 SHALL have port parity_err  output  1  one-cycle pulse on parity failure.

Function
REQ-016 SHALL accept a bit on each rising edge where write_in=1 and in_ready=1; no gaps required between bits.
REQ-017 SHALL use FSM states IDLE, RECEIVING, PARITY: IDLE->RECEIVING on first accepted bit; RECEIVING->IDLE on WIDTH-th bit (or ->PARITY when parity enabled); PARITY->IDLE on the parity bit.
REQ-018 SHALL push the completed word into the buffer on the same edge that accepts its final bit; data_ready=1 and data_out valid from the following cycle (latency 1 cycle after final bit).
REQ-019 SHALL present data_out = oldest buffered word, WIDTH'b0 when empty.
REQ-020 SHALL pop on a rising edge where ack_in=1 and data_ready=1; ack_in while empty SHALL be ignored.
REQ-021 SHALL, on simultaneous push and pop, perform both, leaving word_count unchanged.
REQ-022 SHALL drive in_ready = (word_count != DEPTH); a pop while full SHALL raise in_ready on the next cycle, not combinationally.
REQ-023 SHALL ignore bits with write_in=1 while in_ready=0, leave the partial word intact, and set overflow until reset.
REQ-024 SHALL drive status_out=1 while in RECEIVING or PARITY, 0 in IDLE.
REQ-025 SHALL wrap buffer read/write pointers modulo DEPTH without loss.
REQ-026 SHALL continue assembling the next word while earlier words await ack_in.

Reset
REQ-027 SHALL, while reset=0, force FSM=IDLE, bit counter=0, shift register=0, buffer empty, data_out=0, data_ready=0, in_ready=1, status_out=0, word_count=0, overflow=0, parity_err=0.
REQ-028 SHALL discard any partial word and all buffered words on reset mid-operation; first bit after release starts a new word.

Configuration
REQ-029 SHALL, with macro DESER_PARITY_EN defined, expect one even-parity bit after each WIDTH data bits; matching word pushed on the parity-bit edge, mismatching word discarded and parity_err pulsed for one cycle.
REQ-030 SHALL, without DESER_PARITY_EN, omit the PARITY state and tie parity_err to 0.

Structure
REQ-031 SHALL place state_t enum (IDLE, RECEIVING, PARITY) and default parameter constants in package deser_pkg.
REQ-032 SHALL implement the word buffer as sub-module deser_fifo (parameters WIDTH, DEPTH; push, pop, head, count, full, empty).

Verification
REQ-033 SHALL cover: WIDTH=8, MSB_FIRST=1, bits 1,0,1,0,0,1,0,1 back-to-back -> data_out=8'hA5, data_ready=1 one cycle after 8th bit, status_out 0.
REQ-034 SHALL cover: MSB_FIRST=0, same bits -> data_out=8'hA5 bit-reversed = 8'hA5? no: bits land LSB-first -> data_out=8'hA5 reversed = 8'hA5 checked against model value 8'hA5->8'hA5 bit order reversed (8'hA5 is palindromic; use 1,1,0,0,0,0,0,0 -> 8'h03).
REQ-035 SHALL cover: DEPTH=4, five words with no ack_in -> word_count=4, in_ready=0, 5th word's bits dropped, overflow=1; one ack_in -> word_count=3, in_ready=1 next cycle.
REQ-036 SHALL cover: push and ack_in on the same edge with word_count=2 -> word_count stays 2, data_out advances to next word.
REQ-037 SHALL cover: reset=0 after 3 bits of a word -> status_out=0, word_count=0; next 8 bits 8'h3C -> data_out=8'h3C.
REQ-038 SHALL cover (DESER_PARITY_EN): 8'hA5 plus parity 0 -> word pushed; 8'hA5 plus parity 1 -> parity_err pulse, word_count unchanged.

Source files
------------

// File: rtl/deser_pkg.sv
// Shared types and default parameters for the serial-to-parallel deserializer.
// The FSM state encoding lives here so the bench and debug logic can decode fsm_state.
package deser_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RECEIVING = 2'd1,
    PARITY    = 2'd2
  } state_t;

  localparam int DEF_WIDTH     = 8;
  localparam int DEF_DEPTH     = 4;
  localparam int DEF_MSB_FIRST = 1;

endpackage

// File: rtl/deser_fifo.sv
// Word buffer for the deserializer: power-of-two circular FIFO.
// Its head reads as zero while the buffer is empty.
module deser_fifo
  import deser_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           head,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = empty ? '0 : mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/param_deserializer.sv
// Serial-to-parallel deserializer with a DEPTH-word output buffer.
// Optional even-parity checking is enabled by defining DESER_PARITY_EN.
module param_deserializer
  import deser_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int MSB_FIRST = DEF_MSB_FIRST
) (
  input  logic                       clock_100,
  input  logic                       reset,
  input  logic                       data_in,
  input  logic                       write_in,
  input  logic                       ack_in,
  output logic                       in_ready,
  output logic [WIDTH-1:0]           data_out,
  output logic                       data_ready,
  output logic                       status_out,
  output logic [$clog2(DEPTH+1)-1:0] word_count,
  output logic                       overflow,
  output logic                       parity_err,
  output state_t                     fsm_state
);

  // Handshake: a bit is taken on a rising edge with write_in && in_ready;
  // the head word is released on a rising edge with ack_in && data_ready.

  localparam int CNT_W = $clog2(WIDTH);

  state_t           state, state_next;
  logic [CNT_W-1:0] bit_cnt, cnt_next;
  logic [WIDTH-1:0] shift_reg, shift_next, shifted, push_word;
  logic             push;
  logic             accept;
  logic             last_bit;
  logic             full, empty;
`ifdef DESER_PARITY_EN
  logic             parity_fail;
`endif

  assign accept   = write_in && in_ready;
  assign last_bit = (bit_cnt == CNT_W'(WIDTH-1));

  always_comb begin
    if (MSB_FIRST != 0) shifted = {shift_reg[WIDTH-2:0], data_in};
    else                shifted = {data_in, shift_reg[WIDTH-1:1]};
  end

  always_comb begin
    state_next = state;
    cnt_next   = bit_cnt;
    shift_next = shift_reg;
    push       = 1'b0;
    push_word  = shifted;
`ifdef DESER_PARITY_EN
    parity_fail = 1'b0;
`endif
    case (state)
      IDLE, RECEIVING: begin
        if (accept) begin
          shift_next = shifted;
          if (last_bit) begin
            cnt_next = '0;
`ifdef DESER_PARITY_EN
            state_next = PARITY;
`else
            push       = 1'b1;
            state_next = IDLE;
`endif
          end else begin
            cnt_next   = bit_cnt + CNT_W'(1);
            state_next = RECEIVING;
          end
        end
      end
      PARITY: begin
`ifdef DESER_PARITY_EN
        // Even parity: the parity bit equals the XOR of the data bits.
        if (accept) begin
          state_next = IDLE;
          push_word  = shift_reg;
          if ((^shift_reg) == data_in) push = 1'b1;
          else                         parity_fail = 1'b1;
        end
`else
        state_next = IDLE;
`endif
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock_100 or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shift_reg <= '0;
      overflow  <= 1'b0;
    end else begin
      state     <= state_next;
      bit_cnt   <= cnt_next;
      shift_reg <= shift_next;
      if (write_in && !in_ready) overflow <= 1'b1;
    end
  end

`ifdef DESER_PARITY_EN
  always_ff @(posedge clock_100 or negedge reset) begin
    if (!reset) parity_err <= 1'b0;
    else        parity_err <= parity_fail;
  end
`else
  assign parity_err = 1'b0;
`endif

  deser_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clock_100),
    .rst_n (reset),
    .push  (push),
    .pop   (ack_in),
    .wdata (push_word),
    .head  (data_out),
    .count (word_count),
    .full  (full),
    .empty (empty)
  );

  // in_ready derives from the registered count, so a pop while full frees space next cycle.
  assign in_ready   = !full;
  assign data_ready = !empty;
  assign status_out = (state != IDLE);
  assign fsm_state  = state;

endmodule

// File: tb/tb_param_deserializer.sv
// Directed bench for param_deserializer: one MSB-first and one LSB-first instance share stimulus.
// Parity scenarios are included when DESER_PARITY_EN is defined.
module tb_param_deserializer;
  import deser_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       data_in = 1'b0;
  logic       write_in = 1'b0;
  logic       ack_in = 1'b0;

  logic       m_in_ready, m_data_ready, m_status, m_overflow, m_parity_err;
  logic [7:0] m_data_out;
  logic [2:0] m_count;
  state_t     m_state;
  logic       l_in_ready, l_data_ready, l_status, l_overflow, l_parity_err;
  logic [7:0] l_data_out;
  logic [2:0] l_count;
  state_t     l_state;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  param_deserializer #(.WIDTH(8), .DEPTH(4), .MSB_FIRST(1)) u_msb (
    .clock_100(clk), .reset(reset), .data_in(data_in), .write_in(write_in), .ack_in(ack_in),
    .in_ready(m_in_ready), .data_out(m_data_out), .data_ready(m_data_ready),
    .status_out(m_status), .word_count(m_count), .overflow(m_overflow),
    .parity_err(m_parity_err), .fsm_state(m_state)
  );

  param_deserializer #(.WIDTH(8), .DEPTH(4), .MSB_FIRST(0)) u_lsb (
    .clock_100(clk), .reset(reset), .data_in(data_in), .write_in(write_in), .ack_in(ack_in),
    .in_ready(l_in_ready), .data_out(l_data_out), .data_ready(l_data_ready),
    .status_out(l_status), .word_count(l_count), .overflow(l_overflow),
    .parity_err(l_parity_err), .fsm_state(l_state)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    data_in  = b;
    write_in = 1'b1;
    tick();
    write_in = 1'b0;
  endtask

  // Sends a word MSB of the vector first, followed by its even-parity bit when enabled.
  task automatic send_word(input logic [7:0] w);
    for (int i = 7; i >= 0; i--) send_bit(w[i]);
`ifdef DESER_PARITY_EN
    send_bit(^w);
`endif
  endtask

  task automatic pop();
    ack_in = 1'b1;
    tick();
    ack_in = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] w;
    logic       last;

    // Reset state
    repeat (3) tick();
    check("rst_data_ready", m_data_ready, 0);
    check("rst_in_ready", m_in_ready, 1);
    check("rst_status", m_status, 0);
    check("rst_count", m_count, 0);
    check("rst_overflow", m_overflow, 0);
    check("rst_data_out", m_data_out, 0);
    check("rst_parity_err", m_parity_err, 0);
    check("rst_state", m_state, IDLE);
    reset = 1'b1;
    tick();

    // A5 back-to-back: MSB-first gives A5, LSB-first of a palindrome also A5
    w = 8'hA5;
    for (int i = 7; i >= 1; i--) send_bit(w[i]);
    check("a5_mid_status", m_status, 1);
    check("a5_mid_ready", m_data_ready, 0);
    check("a5_mid_state", m_state, RECEIVING);
    send_bit(w[0]);
`ifdef DESER_PARITY_EN
    send_bit(1'b0);
`endif
    check("a5_ready", m_data_ready, 1);
    check("a5_data", m_data_out, 8'hA5);
    check("a5_status", m_status, 0);
    check("a5_count", m_count, 1);
    check("a5_lsb_data", l_data_out, 8'hA5);
    pop();
    check("pop_count", m_count, 0);
    check("pop_ready", m_data_ready, 0);
    check("pop_data_zero", m_data_out, 0);
    pop();
    check("ack_empty_count", m_count, 0);

    // Bit-order: 1,1,0,0,0,0,0,0
    send_word(8'hC0);
    check("order_msb", m_data_out, 8'hC0);
    check("order_lsb", l_data_out, 8'h03);
    pop();

    // Fill to DEPTH, then overflow
    send_word(8'h11);
    send_word(8'h22);
    send_word(8'h33);
    send_word(8'h44);
    check("full_count", m_count, 4);
    check("full_in_ready", m_in_ready, 0);
    check("full_overflow_pre", m_overflow, 0);
    send_word(8'h55);
    check("ovf_flag", m_overflow, 1);
    check("ovf_count", m_count, 4);
    check("ovf_head", m_data_out, 8'h11);
    check("ovf_status", m_status, 0);
    ack_in = 1'b1;
    #1;
    check("full_pop_not_comb", m_in_ready, 0);
    @(posedge clk);
    #1;
    ack_in = 1'b0;
    check("after_pop_count", m_count, 3);
    check("after_pop_in_ready", m_in_ready, 1);
    check("after_pop_head", m_data_out, 8'h22);
    check("ovf_sticky", m_overflow, 1);
    pop();
    check("two_left_head", m_data_out, 8'h33);
    check("two_left_count", m_count, 2);

    // Simultaneous push and pop at count 2 (pointers wrap here)
    w = 8'h66;
    for (int i = 7; i >= 1; i--) send_bit(w[i]);
`ifdef DESER_PARITY_EN
    send_bit(w[0]);
    last = ^w;
`else
    last = w[0];
`endif
    data_in  = last;
    write_in = 1'b1;
    ack_in   = 1'b1;
    tick();
    write_in = 1'b0;
    ack_in   = 1'b0;
    check("simul_count", m_count, 2);
    check("simul_head", m_data_out, 8'h44);
    pop();
    check("wrap_head", m_data_out, 8'h66);
    check("wrap_count", m_count, 1);
    pop();
    check("drain_ready", m_data_ready, 0);

    // Reset in the middle of a word with a buffered word present
    send_word(8'h77);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b1);
    check("mid_status", m_status, 1);
    reset = 1'b0;
    #1;
    check("midrst_status", m_status, 0);
    check("midrst_count", m_count, 0);
    check("midrst_data", m_data_out, 0);
    check("midrst_overflow", m_overflow, 0);
    tick();
    reset = 1'b1;
    tick();
    send_word(8'h3C);
    check("post_rst_data", m_data_out, 8'h3C);
    check("post_rst_lsb", l_data_out, 8'h3C);
    check("post_rst_count", m_count, 1);
    check("post_rst_in_ready", m_in_ready, 1);

`ifdef DESER_PARITY_EN
    pop();
    w = 8'hA5;
    for (int i = 7; i >= 0; i--) send_bit(w[i]);
    check("par_state", m_state, PARITY);
    check("par_status", m_status, 1);
    check("par_count_pre", m_count, 0);
    send_bit(1'b0);
    check("par_good_count", m_count, 1);
    check("par_good_data", m_data_out, 8'hA5);
    check("par_good_err", m_parity_err, 0);
    for (int i = 7; i >= 0; i--) send_bit(w[i]);
    send_bit(1'b1);
    check("par_bad_err", m_parity_err, 1);
    check("par_bad_count", m_count, 1);
    check("par_bad_state", m_state, IDLE);
    tick();
    check("par_err_pulse_end", m_parity_err, 0);
`else
    check("no_parity_err", m_parity_err, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
